pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: max consecutive data-memory wait cycles before error.
REQ-002 SHALL have parameter CNT_W, default 16: width of performance counters.
REQ-003 SHALL have ports: clk  in  1  single clock, all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 MemRead_ex  in  1  instruction in EX is a load.
REQ-006 rdAddr_ex  in  5  destination register of EX instruction.
REQ-007 rs1Addr_id, rs2Addr_id  in  5 each  source registers of ID instruction.
REQ-008 rs1Used_id, rs2Used_id  in  1 each  ID instruction reads rs1/rs2.
REQ-009 branchTaken_ex  in  1  branch/jump in EX resolved taken.
REQ-010 memReq_mem  in  1  MEM stage issues load/store this cycle.
REQ-011 memReady_mem  in  1  data memory completes the access this cycle.
REQ-012 pcHold, ifidHold, exmemHold  out  1 each  hold enable for PC, IF_ID, EX_MEM registers.
REQ-013 idexHold  out  1  hold ID_EX register.
REQ-014 ifidFlush, idexBubble, memwbBubble  out  1 each  zero the control bits loaded into IF_ID, ID_EX, MEM_WB.
REQ-015 memErr  out  1  sticky memory-timeout error.
REQ-016 stallCnt, flushCnt  out  CNT_W each  saturating counts of stall cycles and flush events.

Function
REQ-017 All hold/flush/bubble outputs SHALL be combinational from current state and inputs (zero-cycle latency); state and counters SHALL be registered.
REQ-018 FSM states SHALL be RUN, WAIT, ERR.
REQ-019 RUN->WAIT when memReq_mem=1 and memReady_mem=0; RUN stays RUN otherwise.
REQ-020 WAIT->RUN when memReady_mem=1; WAIT->ERR when wait counter equals MEM_TIMEOUT and memReady_mem=0; ERR is left only by rst.
REQ-021 Memory stall (RUN with memReq_mem=1 and memReady_mem=0, or WAIT with memReady_mem=0, or ERR) SHALL assert pcHold, ifidHold, idexHold, exmemHold, memwbBubble and suppress all other actions.
REQ-022 Wait counter SHALL clear on entry to WAIT (value 1 on first WAIT cycle), increment each WAIT cycle, clear on return to RUN.
REQ-023 Load-use hazard: MemRead_ex=1, rdAddr_ex!=0, and (rs1Used_id and rs1Addr_id==rdAddr_ex, or rs2Used_id and rs2Addr_id==rdAddr_ex).
REQ-024 Without memory stall, branchTaken_ex=1 SHALL assert ifidFlush and idexBubble for that cycle only; it overrides a simultaneous load-use hazard.
REQ-025 Without memory stall or branch, load-use hazard SHALL assert pcHold, ifidHold, idexBubble for exactly one cycle.
REQ-026 memErr SHALL be 1 exactly while state is ERR.
REQ-027 stallCnt SHALL increment in every cycle pcHold=1, saturating at all ones; flushCnt SHALL increment in every cycle ifidFlush=1, saturating.
REQ-028 memReady_mem=1 without memReq_mem in RUN SHALL be ignored.

Reset
REQ-029 While rst=1 at posedge: state->RUN, wait counter, stallCnt, flushCnt->0; memErr->0.
REQ-030 While rst=1 all hold/flush/bubble outputs SHALL be 0; rst mid-WAIT or in ERR SHALL return to RUN next cycle.

Structure
REQ-031 FSM state encoding and default MEM_TIMEOUT SHALL live in the shared pipeline package.
REQ-032 A sub-module sat_counter (parameter width, inc, rst, saturating) SHALL be instantiated twice for stallCnt and flushCnt.

Verification
REQ-033 MemRead_ex=1, rdAddr_ex=5, rs2Used_id=1, rs2Addr_id=5 for one cycle -> pcHold=ifidHold=idexBubble=1 that cycle, stallCnt=1 after.
REQ-034 rdAddr_ex=0 same hazard pattern -> no stall, stallCnt stays 0.
REQ-035 branchTaken_ex=1 with simultaneous load-use -> ifidFlush=idexBubble=1, pcHold=0, flushCnt=1.
REQ-036 memReq_mem=1, memReady_mem low 3 cycles then high -> all holds+memwbBubble high 3 cycles, RUN on 4th, stallCnt=3.
REQ-037 memReady_mem held low 20 cycles with MEM_TIMEOUT=15 -> ERR after 16 stall cycles, memErr=1 sticky, cleared by one rst cycle.
REQ-038 Branch during memory stall -> no flush until stall ends, then flush in first RUN cycle with branchTaken_ex still 1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM encoding, default limits,
// the bundle of hazard-control strobes and the load-use detection rule.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } pipe_state_e;

  localparam int MEM_TIMEOUT_DEF = 15;
  localparam int CNT_W_DEF       = 16;

  typedef struct packed {
    logic pc_hold;
    logic ifid_hold;
    logic idex_hold;
    logic exmem_hold;
    logic ifid_flush;
    logic idex_bubble;
    logic memwb_bubble;
  } pipe_ctl_t;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic       rs1_used,
    input logic [4:0] rs2,
    input logic       rs2_used
  );
    logic w_rs1_dep;
    logic w_rs2_dep;
    w_rs1_dep = rs1_used && (rs1 == rd);
    w_rs2_dep = rs2_used && (rs2 == rd);
    return mem_read && (rd != 5'd0) && (w_rs1_dep || w_rs2_dep);
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;
  logic             w_sat;

  assign w_sat = &r_cnt;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_inc && !w_sat) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: data-memory wait/timeout FSM, branch flush and
// load-use stall strobes (combinational), plus stall/flush event counters.
//
// state | meaning
// RUN   | normal flow; branch flush and load-use stall may act
// WAIT  | data memory access outstanding; whole pipe frozen
// ERR   | memory timed out; pipe frozen until rst
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemRead_ex,
  input  logic [4:0]       rdAddr_ex,
  input  logic [4:0]       rs1Addr_id,
  input  logic [4:0]       rs2Addr_id,
  input  logic             rs1Used_id,
  input  logic             rs2Used_id,
  input  logic             branchTaken_ex,
  input  logic             memReq_mem,
  input  logic             memReady_mem,
  output logic             pcHold,
  output logic             ifidHold,
  output logic             idexHold,
  output logic             exmemHold,
  output logic             ifidFlush,
  output logic             idexBubble,
  output logic             memwbBubble,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);

  localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(MEM_TIMEOUT);

  pipe_state_e       r_state;
  pipe_state_e       w_state_nxt;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic              w_wait_expired;
  logic              w_mem_stall;
  logic              w_load_use;
  pipe_ctl_t         w_ctl;

  assign w_wait_expired = (r_wait_cnt == WCNT_LIMIT);

  assign w_load_use = load_use_hit(MemRead_ex, rdAddr_ex, rs1Addr_id, rs1Used_id,
                                   rs2Addr_id, rs2Used_id);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (memReq_mem && !memReady_mem) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (memReady_mem) begin
          w_state_nxt = ST_RUN;
        end else if (w_wait_expired) begin
          w_state_nxt = ST_ERR;
        end
      end
      ST_ERR:  w_state_nxt = ST_ERR;
      // Unused encoding is treated as a fault and frozen like a timeout.
      default: w_state_nxt = ST_ERR;
    endcase
  end

  // Counts WAIT cycles: 1 on the first WAIT cycle, so reaching the limit
  // means MEM_TIMEOUT consecutive WAIT cycles have elapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (w_state_nxt == ST_WAIT) begin
      if (r_state == ST_WAIT) begin
        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
      end else begin
        r_wait_cnt <= WCNT_W'(1);
      end
    end else begin
      r_wait_cnt <= '0;
    end
  end

  always_comb begin
    w_mem_stall = 1'b1;
    case (r_state)
      ST_RUN:  w_mem_stall = memReq_mem && !memReady_mem;
      ST_WAIT: w_mem_stall = !memReady_mem;
      ST_ERR:  w_mem_stall = 1'b1;
      default: w_mem_stall = 1'b1;
    endcase
  end

  // Priority: memory stall freezes everything, then branch flush, then load-use.
  always_comb begin
    w_ctl = '0;
    if (!rst) begin
      if (w_mem_stall) begin
        w_ctl.pc_hold      = 1'b1;
        w_ctl.ifid_hold    = 1'b1;
        w_ctl.idex_hold    = 1'b1;
        w_ctl.exmem_hold   = 1'b1;
        w_ctl.memwb_bubble = 1'b1;
      end else if (branchTaken_ex) begin
        w_ctl.ifid_flush  = 1'b1;
        w_ctl.idex_bubble = 1'b1;
      end else if (w_load_use) begin
        w_ctl.pc_hold     = 1'b1;
        w_ctl.ifid_hold   = 1'b1;
        w_ctl.idex_bubble = 1'b1;
      end
    end
  end

  assign pcHold      = w_ctl.pc_hold;
  assign ifidHold    = w_ctl.ifid_hold;
  assign idexHold    = w_ctl.idex_hold;
  assign exmemHold   = w_ctl.exmem_hold;
  assign ifidFlush   = w_ctl.ifid_flush;
  assign idexBubble  = w_ctl.idex_bubble;
  assign memwbBubble = w_ctl.memwb_bubble;
  assign memErr      = (r_state == ST_ERR);

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .i_rst (rst),
    .i_inc (w_ctl.pc_hold),
    .o_cnt (stallCnt)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .i_rst (rst),
    .i_inc (w_ctl.ifid_flush),
    .o_cnt (flushCnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-scenario stimulus tables, expected
// strobes and counter values queued at drive time and compared at negedge.
module tb_pipe_ctrl;

  localparam int CNT_W = 4;

  // {pcHold, ifidHold, idexHold, exmemHold, ifidFlush, idexBubble, memwbBubble, memErr}
  localparam logic [7:0] E_NONE   = 8'b0000_0000;
  localparam logic [7:0] E_STALL  = 8'b1111_0010;
  localparam logic [7:0] E_ERR    = 8'b1111_0011;
  localparam logic [7:0] E_LU     = 8'b1100_0100;
  localparam logic [7:0] E_BR     = 8'b0000_1100;
  localparam logic [7:0] E_RSTERR = 8'b0000_0001;

  logic             clk = 1'b0;
  logic             rst;
  logic             MemRead_ex;
  logic [4:0]       rdAddr_ex;
  logic [4:0]       rs1Addr_id;
  logic [4:0]       rs2Addr_id;
  logic             rs1Used_id;
  logic             rs2Used_id;
  logic             branchTaken_ex;
  logic             memReq_mem;
  logic             memReady_mem;
  logic             pcHold, ifidHold, idexHold, exmemHold;
  logic             ifidFlush, idexBubble, memwbBubble, memErr;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;
  logic [7:0]       w_outs;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .MEM_TIMEOUT (15),
    .CNT_W       (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .MemRead_ex     (MemRead_ex),
    .rdAddr_ex      (rdAddr_ex),
    .rs1Addr_id     (rs1Addr_id),
    .rs2Addr_id     (rs2Addr_id),
    .rs1Used_id     (rs1Used_id),
    .rs2Used_id     (rs2Used_id),
    .branchTaken_ex (branchTaken_ex),
    .memReq_mem     (memReq_mem),
    .memReady_mem   (memReady_mem),
    .pcHold         (pcHold),
    .ifidHold       (ifidHold),
    .idexHold       (idexHold),
    .exmemHold      (exmemHold),
    .ifidFlush      (ifidFlush),
    .idexBubble     (idexBubble),
    .memwbBubble    (memwbBubble),
    .memErr         (memErr),
    .stallCnt       (stallCnt),
    .flushCnt       (flushCnt)
  );

  assign w_outs = {pcHold, ifidHold, idexHold, exmemHold,
                   ifidFlush, idexBubble, memwbBubble, memErr};

  typedef struct {
    logic       r;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       br;
    logic       req;
    logic       rdy;
    logic [7:0] exp;
  } step_t;

  typedef struct {
    string            name;
    logic [7:0]       outs;
    logic [CNT_W-1:0] cs;
    logic [CNT_W-1:0] cf;
  } exp_t;

  exp_t             sb[$];
  int               errors = 0;
  int               checks = 0;
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;

  function automatic step_t st(input logic r, input logic mr, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic br, input logic req, input logic rdy,
                               input logic [7:0] exp);
    step_t s;
    s.r = r; s.mr = mr; s.rd = rd; s.rs1 = rs1; s.u1 = u1;
    s.rs2 = rs2; s.u2 = u2; s.br = br; s.req = req; s.rdy = rdy; s.exp = exp;
    return s;
  endfunction

  // Drive one cycle of stimulus and queue what it must produce. Counter
  // expectations are the values visible during this cycle (before its edge).
  task automatic apply(input step_t s, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = s.r; MemRead_ex = s.mr; rdAddr_ex = s.rd;
    rs1Addr_id = s.rs1; rs1Used_id = s.u1; rs2Addr_id = s.rs2; rs2Used_id = s.u2;
    branchTaken_ex = s.br; memReq_mem = s.req; memReady_mem = s.rdy;
    e.name = nm; e.outs = s.exp; e.cs = m_stall; e.cf = m_flush;
    sb.push_back(e);
    if (s.r) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (s.exp[7] && (m_stall != '1)) m_stall = m_stall + 1'b1;
      if (s.exp[3] && (m_flush != '1)) m_flush = m_flush + 1'b1;
    end
  endtask

  task automatic test_reset();
    step_t t[$];
    exp_t  e;
    t.push_back(st(1, 1, 5'd5, 5'd0, 0, 5'd5, 1, 1, 1, 0, E_NONE));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E_NONE));
    foreach (t[i]) begin
      apply(t[i], "reset");
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (w_outs !== e.outs) begin
        errors++;
        $display("FAIL %s[%0d] outs: got %b expected %b", e.name, i, w_outs, e.outs);
      end
      checks++;
      if (stallCnt !== e.cs || flushCnt !== e.cf) begin
        errors++;
        $display("FAIL %s[%0d] counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 e.name, i, stallCnt, flushCnt, e.cs, e.cf);
      end
    end
  endtask

  task automatic test_load_use();
    step_t t[$];
    exp_t  e;
    t.push_back(st(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E_NONE));
    t.push_back(st(0, 1, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0, 0, E_LU));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E_NONE));
    t.push_back(st(0, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0, E_NONE));
    t.push_back(st(0, 1, 5'd7, 5'd7, 0, 5'd3, 1, 0, 0, 0, E_NONE));
    t.push_back(st(0, 1, 5'd7, 5'd7, 1, 5'd3, 0, 0, 0, 0, E_LU));
    t.push_back(st(0, 0, 5'd7, 5'd7, 1, 5'd7, 1, 0, 0, 0, E_NONE));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, E_NONE));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E_NONE));
    foreach (t[i]) begin
      apply(t[i], "load_use");
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (w_outs !== e.outs) begin
        errors++;
        $display("FAIL %s[%0d] outs: got %b expected %b", e.name, i, w_outs, e.outs);
      end
      checks++;
      if (stallCnt !== e.cs || flushCnt !== e.cf) begin
        errors++;
        $display("FAIL %s[%0d] counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 e.name, i, stallCnt, flushCnt, e.cs, e.cf);
      end
    end
  endtask

  task automatic test_branch();
    step_t t[$];
    exp_t  e;
    t.push_back(st(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E_NONE));
    t.push_back(st(0, 1, 5'd5, 5'd0, 0, 5'd5, 1, 1, 0, 0, E_BR));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E_NONE));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, E_BR));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 1, E_BR));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E_NONE));
    foreach (t[i]) begin
      apply(t[i], "branch");
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (w_outs !== e.outs) begin
        errors++;
        $display("FAIL %s[%0d] outs: got %b expected %b", e.name, i, w_outs, e.outs);
      end
      checks++;
      if (stallCnt !== e.cs || flushCnt !== e.cf) begin
        errors++;
        $display("FAIL %s[%0d] counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 e.name, i, stallCnt, flushCnt, e.cs, e.cf);
      end
    end
  endtask

  // Short wait, return to RUN, then a 15-cycle wait that only completes
  // without error if the wait counter was cleared after the first one.
  task automatic test_mem_stall();
    step_t t[$];
    exp_t  e;
    t.push_back(st(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E_NONE));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, E_STALL));
    t.push_back(st(0, 1, 5'd5, 5'd0, 0, 5'd5, 1, 0, 1, 0, E_STALL));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, E_STALL));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, E_NONE));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E_NONE));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, E_NONE));
    for (int k = 0; k < 15; k++) t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, E_STALL));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, E_NONE));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E_NONE));
    foreach (t[i]) begin
      apply(t[i], "mem_stall");
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (w_outs !== e.outs) begin
        errors++;
        $display("FAIL %s[%0d] outs: got %b expected %b", e.name, i, w_outs, e.outs);
      end
      checks++;
      if (stallCnt !== e.cs || flushCnt !== e.cf) begin
        errors++;
        $display("FAIL %s[%0d] counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 e.name, i, stallCnt, flushCnt, e.cs, e.cf);
      end
    end
  endtask

  // 16 stall cycles reach ERR; ready afterwards is ignored; stallCnt saturates.
  task automatic test_timeout();
    step_t t[$];
    exp_t  e;
    t.push_back(st(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E_NONE));
    for (int k = 0; k < 20; k++)
      t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, (k < 16) ? E_STALL : E_ERR));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 1, E_ERR));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, E_ERR));
    t.push_back(st(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, E_RSTERR));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E_NONE));
    foreach (t[i]) begin
      apply(t[i], "timeout");
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (w_outs !== e.outs) begin
        errors++;
        $display("FAIL %s[%0d] outs: got %b expected %b", e.name, i, w_outs, e.outs);
      end
      checks++;
      if (stallCnt !== e.cs || flushCnt !== e.cf) begin
        errors++;
        $display("FAIL %s[%0d] counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 e.name, i, stallCnt, flushCnt, e.cs, e.cf);
      end
    end
  endtask

  task automatic test_branch_during_stall();
    step_t t[$];
    exp_t  e;
    t.push_back(st(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E_NONE));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, E_STALL));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, E_STALL));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 1, E_BR));
    t.push_back(st(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, E_NONE));
    foreach (t[i]) begin
      apply(t[i], "branch_in_stall");
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (w_outs !== e.outs) begin
        errors++;
        $display("FAIL %s[%0d] outs: got %b expected %b", e.name, i, w_outs, e.outs);
      end
      checks++;
      if (stallCnt !== e.cs || flushCnt !== e.cf) begin
        errors++;
        $display("FAIL %s[%0d] counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 e.name, i, stallCnt, flushCnt, e.cs, e.cf);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; MemRead_ex = 1'b0; rdAddr_ex = '0; rs1Addr_id = '0; rs2Addr_id = '0;
    rs1Used_id = 1'b0; rs2Used_id = 1'b0; branchTaken_ex = 1'b0;
    memReq_mem = 1'b0; memReady_mem = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_load_use();
    test_branch();
    test_mem_stall();
    test_timeout();
    test_branch_during_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
